// File: rtl/stopwatch_7seg_if.sv
// Button inputs and display/status outputs of the MM:SS stopwatch.
// The master side is the board (debouncers, display drivers); the slave side is the stopwatch.
interface stopwatch_7seg_if;
    logic       b_run;
    logic       b_clr;
    logic [6:0] sec_0;
    logic [6:0] sec_1;
    logic [6:0] min_0;
    logic [6:0] min_1;
    logic       s_run;
    logic       s_hld;

    modport master (
        output b_run, b_clr,
        input  sec_0, sec_1, min_0, min_1, s_run, s_hld
    );

    modport slave (
        input  b_run, b_clr,
        output sec_0, sec_1, min_0, min_1, s_run, s_hld
    );
endinterface

// File: rtl/stopwatch_7seg.sv
// MM:SS stopwatch (00:00-59:59) with run/stop and clear/split buttons, driving four
// active-high 7-segment digits (bit0=a .. bit6=g) plus run and hold status LEDs.
module stopwatch_7seg #(
    parameter int unsigned SPN = 50_000_000
) (
    input  logic          clk,
    input  logic          rst,
    stopwatch_7seg_if.slave sw
);

    localparam int unsigned    PW     = $clog2(SPN);
    localparam logic [PW-1:0]  P_LAST = PW'(SPN - 1);

    logic          r_b_run_q;
    logic          r_b_clr_q;
    logic          r_run;
    logic          r_hld;
    logic [PW-1:0] r_presc;
    logic [3:0]    r_s0, r_s1, r_m0, r_m1;
    logic [3:0]    r_sp_s0, r_sp_s1, r_sp_m0, r_sp_m1;

    logic          w_run_ev;
    logic          w_clr_ev;
    logic          w_tick;
    logic          w_clear;
    logic          w_split;
    logic [3:0]    w_d_s0, w_d_s1, w_d_m0, w_d_m1;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'h3F;
            4'd1:    f_seg = 7'h06;
            4'd2:    f_seg = 7'h5B;
            4'd3:    f_seg = 7'h4F;
            4'd4:    f_seg = 7'h66;
            4'd5:    f_seg = 7'h6D;
            4'd6:    f_seg = 7'h7D;
            4'd7:    f_seg = 7'h07;
            4'd8:    f_seg = 7'h7F;
            4'd9:    f_seg = 7'h6F;
            default: f_seg = 7'h00;
        endcase
    endfunction

    assign w_run_ev = sw.b_run & ~r_b_run_q;
    assign w_clr_ev = sw.b_clr & ~r_b_clr_q;
    assign w_tick   = r_run & (r_presc == P_LAST);
    // clr/split branch is chosen from the state before this edge
    assign w_clear  = w_clr_ev & ~r_run & ~r_hld;
    assign w_split  = w_clr_ev &  r_run & ~r_hld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_b_run_q <= 1'b0;
            r_b_clr_q <= 1'b0;
            r_run     <= 1'b0;
            r_hld     <= 1'b0;
        end else begin
            r_b_run_q <= sw.b_run;
            r_b_clr_q <= sw.b_clr;
            if (w_run_ev)
                r_run <= ~r_run;
            // hold sets only when running and not held; every other case releases it
            if (w_clr_ev)
                r_hld <= r_run & ~r_hld;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_clear)
            r_presc <= '0;
        else if (r_run)
            r_presc <= (r_presc == P_LAST) ? '0 : r_presc + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_s0 <= '0;
            r_s1 <= '0;
            r_m0 <= '0;
            r_m1 <= '0;
        end else if (w_tick) begin
            if (r_s0 != 4'd9) begin
                r_s0 <= r_s0 + 4'd1;
            end else begin
                r_s0 <= '0;
                if (r_s1 != 4'd5) begin
                    r_s1 <= r_s1 + 4'd1;
                end else begin
                    r_s1 <= '0;
                    if (r_m0 != 4'd9) begin
                        r_m0 <= r_m0 + 4'd1;
                    end else begin
                        r_m0 <= '0;
                        r_m1 <= (r_m1 != 4'd5) ? r_m1 + 4'd1 : '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp_s0 <= '0;
            r_sp_s1 <= '0;
            r_sp_m0 <= '0;
            r_sp_m1 <= '0;
        end else if (w_split) begin
            r_sp_s0 <= r_s0;
            r_sp_s1 <= r_s1;
            r_sp_m0 <= r_m0;
            r_sp_m1 <= r_m1;
        end
    end

    assign w_d_s0 = r_hld ? r_sp_s0 : r_s0;
    assign w_d_s1 = r_hld ? r_sp_s1 : r_s1;
    assign w_d_m0 = r_hld ? r_sp_m0 : r_m0;
    assign w_d_m1 = r_hld ? r_sp_m1 : r_m1;

    assign sw.sec_0 = f_seg(w_d_s0);
    assign sw.sec_1 = f_seg(w_d_s1);
    assign sw.min_0 = f_seg(w_d_m0);
    assign sw.min_1 = f_seg(w_d_m1);
    assign sw.s_run = r_run;
    assign sw.s_hld = r_hld;

endmodule

// File: tb/tb_stopwatch_7seg.sv
// Self-checking bench: two stopwatches (SPN=5 and SPN=2) share reset and buttons and are
// compared every cycle against a seconds-count reference model, plus directed scenario checks.
module tb_stopwatch_7seg;

    logic clk = 1'b0;
    logic rst = 1'b1;

    stopwatch_7seg_if if5 ();
    stopwatch_7seg_if if2 ();

    stopwatch_7seg #(.SPN(5)) u_dut5 (.clk(clk), .rst(rst), .sw(if5.slave));
    stopwatch_7seg #(.SPN(2)) u_dut2 (.clk(clk), .rst(rst), .sw(if2.slave));

    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    localparam logic [6:0] Z = 7'h3F;

    // Reference model: elapsed time kept as whole seconds 0..3599
    int m_spn   [2] = '{5, 2};
    int m_sec   [2];
    int m_pc    [2];
    int m_split [2];
    bit m_run   [2];
    bit m_hld   [2];
    bit m_prun;
    bit m_pclr;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] model_out(input int k);
        int d;
        d = m_hld[k] ? m_split[k] : m_sec[k];
        return {m_run[k], m_hld[k], seg_tab[d / 600], seg_tab[(d / 60) % 10],
                seg_tab[(d % 60) / 10], seg_tab[d % 10]};
    endfunction

    function automatic logic [29:0] dut_out(input int k);
        if (k == 0)
            return {if5.s_run, if5.s_hld, if5.min_1, if5.min_0, if5.sec_1, if5.sec_0};
        return {if2.s_run, if2.s_hld, if2.min_1, if2.min_0, if2.sec_1, if2.sec_0};
    endfunction

    task automatic model_edge(input bit r, input bit br, input bit bc);
        bit re, ce, tick, run0;
        if (r) begin
            for (int k = 0; k < 2; k++) begin
                m_sec[k] = 0; m_pc[k] = 0; m_split[k] = 0;
                m_run[k] = 0; m_hld[k] = 0;
            end
            m_prun = 0;
            m_pclr = 0;
            return;
        end
        re = br && !m_prun;
        ce = bc && !m_pclr;
        m_prun = br;
        m_pclr = bc;
        for (int k = 0; k < 2; k++) begin
            run0 = m_run[k];
            tick = run0 && (m_pc[k] == m_spn[k] - 1);
            if (run0)
                m_pc[k] = (m_pc[k] + 1) % m_spn[k];
            if (ce) begin
                if (run0) begin
                    if (!m_hld[k])
                        m_split[k] = m_sec[k];
                    m_hld[k] = !m_hld[k];
                end else if (m_hld[k]) begin
                    m_hld[k] = 0;
                end else begin
                    m_sec[k] = 0;
                    m_pc[k]  = 0;
                end
            end
            if (tick)
                m_sec[k] = (m_sec[k] + 1) % 3600;
            if (re)
                m_run[k] = !run0;
        end
    endtask

    task automatic step(input bit r, input bit br, input bit bc);
        rst       = r;
        if5.b_run = br;
        if2.b_run = br;
        if5.b_clr = bc;
        if2.b_clr = bc;
        @(posedge clk);
        model_edge(r, br, bc);
        #1;
        check_val("dut5_cycle", {2'b00, dut_out(0)}, {2'b00, model_out(0)});
        check_val("dut2_cycle", {2'b00, dut_out(1)}, {2'b00, model_out(1)});
    endtask

    initial begin
        bit br, bc, r;
        if5.b_run = 1'b0; if5.b_clr = 1'b0;
        if2.b_run = 1'b0; if2.b_clr = 1'b0;

        // Reset and idle
        step(1, 0, 0);
        step(1, 0, 0);
        check_val("reset5", {2'b00, dut_out(0)}, {2'b00, 2'b00, Z, Z, Z, Z});
        check_val("reset2", {2'b00, dut_out(1)}, {2'b00, 2'b00, Z, Z, Z, Z});
        repeat (100) step(0, 0, 0);
        check_val("idle5", {2'b00, dut_out(0)}, {2'b00, 2'b00, Z, Z, Z, Z});

        // Start with a 10-cycle press, count to 13:13
        step(0, 1, 0);
        check_val("run_rise", 32'(dut_out(0)[29]), 32'd1);
        for (int i = 0; i < 3965; i++) step(0, (i < 9), 0);
        check_val("single_toggle", 32'(dut_out(0)[29]), 32'd1);
        check_val("disp_1313", 32'(dut_out(0)[27:0]), 32'({7'h06, 7'h4F, 7'h06, 7'h4F}));

        // Run 3 s, stop, stay frozen, then clear
        step(1, 0, 0);
        step(0, 1, 0);
        repeat (15) step(0, 0, 0);
        repeat (3) step(0, 1, 0);
        check_val("stop_run", 32'(dut_out(0)[29]), 32'd0);
        check_val("stop_0003", 32'(dut_out(0)[27:0]), 32'({Z, Z, Z, 7'h4F}));
        repeat (50) step(0, 0, 0);
        check_val("frozen_0003", 32'(dut_out(0)[27:0]), 32'({Z, Z, Z, 7'h4F}));
        step(0, 0, 1);
        step(0, 0, 0);
        check_val("clear", {2'b00, dut_out(0)}, {2'b00, 2'b00, Z, Z, Z, Z});

        // Split at 10 s, release at 17 s
        step(1, 0, 0);
        step(0, 1, 0);
        repeat (50) step(0, 0, 0);
        step(0, 0, 1);
        check_val("split_hld", 32'(dut_out(0)[29:28]), 32'd3);
        check_val("split_0010", 32'(dut_out(0)[27:0]), 32'({Z, Z, 7'h06, Z}));
        for (int i = 0; i < 34; i++) step(0, 0, (i == 0));
        check_val("held_0010", 32'(dut_out(0)[27:0]), 32'({Z, Z, 7'h06, Z}));
        step(0, 0, 1);
        check_val("resume_hld", 32'(dut_out(0)[29:28]), 32'd2);
        check_val("resume_0017", 32'(dut_out(0)[27:0]), 32'({Z, Z, 7'h06, 7'h07}));

        // Wrap after 3600 s on the SPN=2 instance
        step(1, 0, 0);
        step(0, 1, 0);
        repeat (7200) step(0, 0, 0);
        check_val("wrap2", {2'b00, dut_out(1)}, {2'b00, 2'b10, Z, Z, Z, Z});
        repeat (2) step(0, 0, 0);
        check_val("wrap2_cont", {2'b00, dut_out(1)}, {2'b00, 2'b10, Z, Z, Z, 7'h06});

        // Reset mid-count at 05:42
        step(1, 0, 0);
        step(0, 1, 0);
        repeat (1710) step(0, 0, 0);
        check_val("disp_0542", 32'(dut_out(0)[27:0]), 32'({Z, 7'h6D, 7'h66, 7'h5B}));
        step(1, 0, 0);
        check_val("mid_reset", {2'b00, dut_out(0)}, {2'b00, 2'b00, Z, Z, Z, Z});

        // Simultaneous run and clear edges while stopped
        step(0, 1, 0);
        repeat (20) step(0, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 1, 1);
        check_val("simul", {2'b00, dut_out(0)}, {2'b00, 2'b10, Z, Z, Z, Z});

        // Random button activity with rare resets
        step(1, 0, 0);
        br = 0;
        bc = 0;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 29) == 0) br = !br;
            if ($urandom_range(0, 29) == 0) bc = !bc;
            r = ($urandom_range(0, 4999) == 0);
            step(r, br, bc);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
